// File: rtl/uart_pkg.sv
// Shared UART definitions for the transmitter and receiver: parity modes,
// transmitter state encoding and the minimum supported data length.
package uart_pkg;

  localparam logic [1:0] PAR_NONE = 2'd0;
  localparam logic [1:0] PAR_EVEN = 2'd1;
  localparam logic [1:0] PAR_ODD  = 2'd2;

  localparam int MIN_DATA_BITS = 5;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4
  } tx_state_t;

  function automatic logic parity_out(input logic acc, input logic odd);
    return acc ^ odd;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts OVERSAMPLE baud ticks per bit and flags the tick
// that closes the current bit. Cleared while the owner is idle.
module uart_bit_timer #(
  parameter int OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic i_tick,
  input  logic i_clear,
  output logic o_bit_end
);

  localparam int            CW   = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);

  logic [CW-1:0] r_count;

  assign o_bit_end = i_tick && (r_count == LAST);

  // Tick counter; wraps to zero on the bit-closing tick
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= {CW{1'b0}};
    end else if (i_clear) begin
      r_count <= {CW{1'b0}};
    end else if (i_tick) begin
      if (r_count == LAST) begin
        r_count <= {CW{1'b0}};
      end else begin
        r_count <= r_count + CW'(1);
      end
    end else begin
      r_count <= r_count;
    end
  end

endmodule

// File: rtl/uart_tx_framed.sv
// UART transmitter: start bit, 5..DATA_LENGTH LSB-first data bits, optional
// parity and one or two stop bits. Frame format is latched with each word.
module uart_tx_framed
  import uart_pkg::*;
#(
  parameter int DATA_LENGTH = 8,
  parameter int OVERSAMPLE  = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             baud_timer,
  input  logic                             tx_valid,
  output logic                             tx_ready,
  input  logic [DATA_LENGTH-1:0]           tx_data,
  input  logic [$clog2(DATA_LENGTH+1)-1:0] cfg_data_bits,
  input  logic [1:0]                       cfg_parity,
  input  logic                             cfg_stop2,
  output logic                             tx_busy,
  output logic                             tx_done,
  output logic                             tx
);

  localparam int BW = $clog2(DATA_LENGTH + 1);

  tx_state_t              r_state, w_state;
  logic [DATA_LENGTH-1:0] r_shift, w_shift;
  logic [BW-1:0]          r_bit_idx, w_bit_idx;
  logic [BW-1:0]          r_data_bits, w_data_bits;
  logic [BW-1:0]          w_eff_bits;
  logic                   r_par_en, w_par_en;
  logic                   r_par_odd, w_par_odd;
  logic                   r_stop2, w_stop2;
  logic                   r_stop_idx, w_stop_idx;
  logic                   r_par_acc, w_par_acc;
  logic                   r_tx, w_tx;
  logic                   r_done, w_done;
  logic                   w_bit_end;
  logic                   w_idle;

  assign w_idle   = (r_state == TX_IDLE);
  assign tx_ready = w_idle;
  assign tx_busy  = !w_idle;
  assign tx_done  = r_done;
  assign tx       = r_tx;

  // Out-of-range lengths fall back to the full data width
  assign w_eff_bits = ((cfg_data_bits < BW'(MIN_DATA_BITS)) || (cfg_data_bits > BW'(DATA_LENGTH)))
                      ? BW'(DATA_LENGTH) : cfg_data_bits;

  uart_bit_timer #(
    .OVERSAMPLE(OVERSAMPLE)
  ) u_bit_timer (
    .clk      (clk),
    .reset    (reset),
    .i_tick   (baud_timer),
    .i_clear  (w_idle),
    .o_bit_end(w_bit_end)
  );

  // Next-state, datapath and line-value logic
  always_comb begin
    w_state     = r_state;
    w_shift     = r_shift;
    w_bit_idx   = r_bit_idx;
    w_data_bits = r_data_bits;
    w_par_en    = r_par_en;
    w_par_odd   = r_par_odd;
    w_stop2     = r_stop2;
    w_stop_idx  = r_stop_idx;
    w_par_acc   = r_par_acc;
    w_done      = 1'b0;
    w_tx        = 1'b1;

    case (r_state)
      TX_IDLE: begin
        if (tx_valid) begin
          w_state     = TX_START;
          w_shift     = tx_data;
          w_bit_idx   = {BW{1'b0}};
          w_data_bits = w_eff_bits;
          w_par_en    = (cfg_parity == PAR_EVEN) || (cfg_parity == PAR_ODD);
          w_par_odd   = (cfg_parity == PAR_ODD);
          w_stop2     = cfg_stop2;
          w_stop_idx  = 1'b0;
          w_par_acc   = 1'b0;
        end else begin
          w_state = TX_IDLE;
        end
      end
      TX_START: begin
        if (w_bit_end) begin
          w_state = TX_DATA;
        end else begin
          w_state = TX_START;
        end
      end
      TX_DATA: begin
        if (w_bit_end) begin
          // Parity is folded in one bit at a time as each bit leaves the shifter
          w_par_acc = r_par_acc ^ r_shift[0];
          w_shift   = {1'b1, r_shift[DATA_LENGTH-1:1]};
          if (r_bit_idx == (r_data_bits - BW'(1))) begin
            w_bit_idx = {BW{1'b0}};
            if (r_par_en) begin
              w_state = TX_PARITY;
            end else begin
              w_state = TX_STOP;
            end
          end else begin
            w_bit_idx = r_bit_idx + BW'(1);
          end
        end else begin
          w_state = TX_DATA;
        end
      end
      TX_PARITY: begin
        if (w_bit_end) begin
          w_state = TX_STOP;
        end else begin
          w_state = TX_PARITY;
        end
      end
      TX_STOP: begin
        if (w_bit_end) begin
          if (r_stop2 && !r_stop_idx) begin
            w_stop_idx = 1'b1;
          end else begin
            w_stop_idx = 1'b0;
            w_state    = TX_IDLE;
            w_done     = 1'b1;
          end
        end else begin
          w_state = TX_STOP;
        end
      end
      default: begin
        w_state = TX_IDLE;
      end
    endcase

    // The line register takes the value of the state being entered
    case (w_state)
      TX_START:  w_tx = 1'b0;
      TX_DATA:   w_tx = w_shift[0];
      TX_PARITY: w_tx = parity_out(w_par_acc, r_par_odd);
      default:   w_tx = 1'b1;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= TX_IDLE;
      r_shift     <= {DATA_LENGTH{1'b0}};
      r_bit_idx   <= {BW{1'b0}};
      r_data_bits <= {BW{1'b0}};
      r_par_en    <= 1'b0;
      r_par_odd   <= 1'b0;
      r_stop2     <= 1'b0;
      r_stop_idx  <= 1'b0;
      r_par_acc   <= 1'b0;
      r_tx        <= 1'b1;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_shift     <= w_shift;
      r_bit_idx   <= w_bit_idx;
      r_data_bits <= w_data_bits;
      r_par_en    <= w_par_en;
      r_par_odd   <= w_par_odd;
      r_stop2     <= w_stop2;
      r_stop_idx  <= w_stop_idx;
      r_par_acc   <= w_par_acc;
      r_tx        <= w_tx;
      r_done      <= w_done;
    end
  end

endmodule

// File: tb/tb_uart_tx_framed.sv
// Self-checking bench for uart_tx_framed: frames are predicted as bit lists
// and every clock the line is compared against the bit the tick count selects.
module tb_uart_tx_framed;

  localparam int DL = 8;
  localparam int OS = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       baud_timer = 1'b0;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] tx_data = 8'h00;
  logic [3:0] cfg_data_bits = 4'd8;
  logic [1:0] cfg_parity = 2'd0;
  logic       cfg_stop2 = 1'b0;
  logic       tx_busy;
  logic       tx_done;
  logic       tx;

  int checks = 0;
  int failures = 0;
  int tick_div = 1;
  int tick_cnt = 0;
  logic exp_bits[$];

  uart_tx_framed #(.DATA_LENGTH(DL), .OVERSAMPLE(OS)) dut (
    .clk          (clk),
    .reset        (reset),
    .baud_timer   (baud_timer),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .tx_data      (tx_data),
    .cfg_data_bits(cfg_data_bits),
    .cfg_parity   (cfg_parity),
    .cfg_stop2    (cfg_stop2),
    .tx_busy      (tx_busy),
    .tx_done      (tx_done),
    .tx           (tx)
  );

  always #5 clk = ~clk;

  // One-clock baud tick every tick_div clocks, changed away from the active edge
  always @(negedge clk) begin
    if (tick_cnt >= tick_div - 1) begin
      tick_cnt   <= 0;
      baud_timer <= 1'b1;
    end else begin
      tick_cnt   <= tick_cnt + 1;
      baud_timer <= 1'b0;
    end
  end

  // Reference frame: start, data LSB first, optional parity, stop bit(s)
  task automatic build_frame(input logic [7:0] d, input int nb_cfg, input int par, input bit s2);
    int nb;
    int ones;
    nb = (nb_cfg < 5 || nb_cfg > DL) ? DL : nb_cfg;
    ones = 0;
    exp_bits.delete();
    exp_bits.push_back(1'b0);
    for (int i = 0; i < nb; i++) begin
      exp_bits.push_back(d[i]);
      ones += int'(d[i]);
    end
    if (par == 1) exp_bits.push_back((ones % 2) == 1);
    else if (par == 2) exp_bits.push_back((ones % 2) == 0);
    exp_bits.push_back(1'b1);
    if (s2) exp_bits.push_back(1'b1);
  endtask

  task automatic drive_word(input logic [7:0] d, input int nb, input int par, input bit s2);
    tx_valid      = 1'b1;
    tx_data       = d;
    cfg_data_bits = 4'(nb);
    cfg_parity    = 2'(par);
    cfg_stop2     = s2;
  endtask

  // Words are presented before the next rising edge, which accepts them
  task automatic expect_frame(input logic [7:0] d, input int nb, input int par, input bit s2,
                              input bit hold, input logic [7:0] nd, input int nnb,
                              input int npar, input bit ns2, output int clks);
    int bi;
    int tk;
    int cyc;
    bit fin;
    bit bad;
    bit t;
    logic ex;
    build_frame(d, nb, par, s2);
    @(posedge clk);
    #1;
    checks++;
    if (tx !== 1'b0 || tx_busy !== 1'b1 || tx_ready !== 1'b0) begin
      failures++;
      $display("FAIL accept: tx=%b busy=%b ready=%b, expected tx=0 busy=1 ready=0", tx, tx_busy, tx_ready);
    end
    @(negedge clk);
    if (hold) begin
      drive_word(nd, nnb, npar, ns2);
    end else begin
      tx_valid      = 1'b0;
      tx_data       = 8'($urandom);
      cfg_data_bits = 4'($urandom);
      cfg_parity    = 2'($urandom);
      cfg_stop2     = 1'($urandom);
    end
    bi = 0; tk = 0; cyc = 0; fin = 1'b0; bad = 1'b0;
    while (!fin && !bad && cyc < 4000) begin
      @(posedge clk);
      t = baud_timer;
      #1;
      cyc++;
      if (t) begin
        tk++;
        if (tk == OS) begin
          tk = 0;
          bi++;
        end
      end
      checks++;
      if (bi == exp_bits.size()) begin
        fin = 1'b1;
        if (tx !== 1'b1 || tx_done !== 1'b1 || tx_busy !== 1'b0 || tx_ready !== 1'b1) begin
          failures++;
          bad = 1'b1;
          $display("FAIL frame_end d=%h: tx=%b done=%b busy=%b ready=%b, expected 1 1 0 1", d, tx, tx_done, tx_busy, tx_ready);
        end
      end else begin
        ex = exp_bits[bi];
        if (tx !== ex || tx_done !== 1'b0 || tx_busy !== 1'b1 || tx_ready !== 1'b0) begin
          failures++;
          bad = 1'b1;
          $display("FAIL frame_bit d=%h bit=%0d tick=%0d: tx=%b done=%b busy=%b ready=%b, expected tx=%b 0 1 0",
                   d, bi, tk, tx, tx_done, tx_busy, tx_ready, ex);
        end
      end
    end
    if (!fin && !bad) begin
      checks++;
      failures++;
      $display("FAIL frame_timeout d=%h: no tx_done after %0d clks, expected one", d, cyc);
    end
    if (bad) begin
      tx_valid = 1'b0;
      cyc = 0;
      while (tx_busy === 1'b1 && cyc < 4000) begin
        @(posedge clk);
        #1;
        cyc++;
      end
      @(negedge clk);
    end
    clks = cyc;
  endtask

  task automatic test_reset();
    #1 reset = 1'b1;
    #1;
    checks++;
    if (tx !== 1'b1 || tx_done !== 1'b0 || tx_busy !== 1'b0 || tx_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_state: tx=%b done=%b busy=%b ready=%b, expected 1 0 0 1", tx, tx_done, tx_busy, tx_ready);
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_8n1();
    int clks;
    tick_div = 1;
    repeat (3) @(negedge clk);
    drive_word(8'hA5, 8, 0, 1'b0);
    expect_frame(8'hA5, 8, 0, 1'b0, 1'b0, 8'h00, 8, 0, 1'b0, clks);
    checks++;
    if (clks !== 160) begin
      failures++;
      $display("FAIL 8n1_latency: tx_done %0d clks after start, expected 160", clks);
    end
  endtask

  task automatic test_7e2();
    int clks;
    @(negedge clk);
    drive_word(8'hC1, 7, 1, 1'b1);
    expect_frame(8'hC1, 7, 1, 1'b1, 1'b0, 8'h00, 8, 0, 1'b0, clks);
    checks++;
    if (clks !== 11 * OS) begin
      failures++;
      $display("FAIL 7e2_latency: tx_done %0d clks after start, expected %0d", clks, 11 * OS);
    end
  endtask

  task automatic test_5o1_and_bad_len();
    int clks;
    @(negedge clk);
    drive_word(8'h1F, 5, 2, 1'b0);
    expect_frame(8'h1F, 5, 2, 1'b0, 1'b0, 8'h00, 8, 0, 1'b0, clks);
    @(negedge clk);
    drive_word(8'h5A, 3, 0, 1'b0);
    expect_frame(8'h5A, 3, 0, 1'b0, 1'b0, 8'h00, 8, 0, 1'b0, clks);
    @(negedge clk);
    drive_word(8'h33, 15, 1, 1'b0);
    expect_frame(8'h33, 15, 1, 1'b0, 1'b0, 8'h00, 8, 0, 1'b0, clks);
  endtask

  task automatic test_back_to_back();
    int clks;
    @(negedge clk);
    drive_word(8'h96, 8, 0, 1'b0);
    expect_frame(8'h96, 8, 0, 1'b0, 1'b1, 8'h3C, 5, 2, 1'b1, clks);
    expect_frame(8'h3C, 5, 2, 1'b1, 1'b0, 8'h00, 8, 0, 1'b0, clks);
  endtask

  task automatic test_sparse_ticks();
    int clks;
    tick_div = 7;
    repeat (8) @(negedge clk);
    drive_word(8'h6D, 8, 0, 1'b0);
    expect_frame(8'h6D, 8, 0, 1'b0, 1'b0, 8'h00, 8, 0, 1'b0, clks);
    checks++;
    if (clks < 160 * 7 - 6 || clks > 160 * 7) begin
      failures++;
      $display("FAIL sparse_latency: tx_done %0d clks after start, expected %0d..%0d", clks, 160 * 7 - 6, 160 * 7);
    end
    @(negedge clk);
    drive_word(8'hB2, 6, 2, 1'b1);
    expect_frame(8'hB2, 6, 2, 1'b1, 1'b0, 8'h00, 8, 0, 1'b0, clks);
  endtask

  task automatic test_random();
    int clks;
    logic [7:0] d;
    int nb;
    int par;
    bit s2;
    for (int n = 0; n < 8; n++) begin
      tick_div = int'($urandom_range(1, 3));
      repeat (4) @(negedge clk);
      d   = 8'($urandom);
      nb  = int'($urandom_range(0, 15));
      par = int'($urandom_range(0, 3));
      s2  = 1'($urandom);
      drive_word(d, nb, par, s2);
      expect_frame(d, nb, par, s2, 1'b0, 8'h00, 8, 0, 1'b0, clks);
    end
  endtask

  task automatic test_reset_mid_frame();
    int clks;
    tick_div = 1;
    repeat (3) @(negedge clk);
    drive_word(8'hF7, 8, 0, 1'b0);
    @(posedge clk);
    #1;
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (72) @(posedge clk);
    #2;
    checks++;
    if (tx !== 1'b0 || tx_busy !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset: tx=%b busy=%b, expected tx=0 busy=1 in data bit 3", tx, tx_busy);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (tx !== 1'b1 || tx_busy !== 1'b0 || tx_ready !== 1'b1 || tx_done !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: tx=%b busy=%b ready=%b done=%b, expected 1 0 1 0", tx, tx_busy, tx_ready, tx_done);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (tx !== 1'b1 || tx_done !== 1'b0 || tx_busy !== 1'b0 || tx_ready !== 1'b1) begin
        failures++;
        $display("FAIL post_reset cyc=%0d: tx=%b done=%b busy=%b ready=%b, expected 1 0 0 1", i, tx, tx_done, tx_busy, tx_ready);
      end
    end
    @(negedge clk);
    drive_word(8'h4E, 8, 1, 1'b0);
    expect_frame(8'h4E, 8, 1, 1'b0, 1'b0, 8'h00, 8, 0, 1'b0, clks);
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_7e2();
    test_5o1_and_bad_len();
    test_back_to_back();
    test_sparse_ticks();
    test_random();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
